instr_fetch_issue: RTL
======================

Name: instr_fetch_issue

Overview:
- Front end of the multi-cycle core: fetches 16-bit instructions from instruction memory through a req/ack handshake and presents the opcode field to the control decoder.
- Consumes the decoder's branch/jump/halt outputs to compute the next PC.
- Sits between instruction memory and control; owns the PC and the run/halt state.

Parameters:
ADDR_W, 8, instruction address width (word addressed)
INSTR_W, 16, instruction width; opcode = instr[15:12]
RESET_PC, 0, PC value after reset

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse; leaves IDLE and begins fetching
imem_req  output  1  instruction memory request, held until ack
imem_addr  output  ADDR_W  fetch address (= pc while imem_req)
imem_rdata  input  INSTR_W  instruction data, valid when imem_ack
imem_ack  input  1  one-cycle completion strobe from instruction memory
instr  output  INSTR_W  latched current instruction
opcode  output  4  instr[15:12], drives control decoder
instr_valid  output  1  instr/opcode valid for decode/execute
ex_done  input  1  execute finished current instruction; control outputs valid this cycle
branch  input  1  from control decoder
jump  input  1  from control decoder
halt  input  1  from control decoder
alu_zero  input  1  ALU zero flag, branch condition
pc  output  ADDR_W  current PC
halted  output  1  core stopped by halt instruction
retire_cnt  output  16  retired-instruction count, saturating

Behaviour:
- Reset is asynchronous and active-low: clk, rst_n; rst_n low immediately forces all state.
- Reset values: state = IDLE, pc = RESET_PC, instr = 0, retire_cnt = 0. imem_req, instr_valid and halted are all 0.
- States: IDLE, FETCH, ISSUE, HALTED.
- IDLE:
  - start = 1 -> FETCH on the next edge.
  - imem_ack and ex_done are ignored.
- FETCH:
  - imem_req = 1 and imem_addr = pc, held stable until imem_ack.
  - On imem_ack: instr <= imem_rdata, then ISSUE.
  - instr_valid = 0 throughout FETCH.
  - Minimum latency: ack in the first FETCH cycle gives instr_valid in the next cycle.
- ISSUE:
  - instr_valid = 1; instr/opcode held stable.
  - Waits indefinitely for ex_done.
  - On ex_done, sample halt/jump/branch/alu_zero in that cycle. Priority is halt > jump > branch.
    - halt: pc unchanged, go to HALTED, halted = 1.
    - jump: pc <= instr[ADDR_W-1:0], go to FETCH.
    - branch && alu_zero: pc <= pc + 1 + sext(instr[7:0]), truncated to ADDR_W bits (modular wrap), go to FETCH.
    - otherwise: pc <= pc + 1, wrapping from 2^ADDR_W-1 to 0, go to FETCH.
  - Every ex_done in ISSUE, including halt, increments retire_cnt. retire_cnt saturates at 16'hFFFF.
  - instr_valid drops the cycle after ex_done.
- HALTED:
  - Terminal until rst_n; start, imem_ack and ex_done are ignored.
  - imem_req = 0, instr_valid = 0.
  - instr and pc keep their last values.
- Boundary cases:
  - A spurious imem_ack outside FETCH is ignored.
  - An ex_done outside ISSUE is ignored.
  - start while busy is ignored.
  - Reset mid-FETCH drops imem_req asynchronously; any later ack is ignored.
  - branch with alu_zero = 0 is not taken.
  - Simultaneous jump and branch: jump wins.

Decomposition:
- Shared package mips_pkg:
  - OPCODE_W = 4 and INSTR_W.
  - Field positions: OPC_HI = 15, OPC_LO = 12, BR_OFF_W = 8.
  - Fetch state encoding as a typedef or localparams: IDLE = 2'd0, FETCH = 2'd1, ISSUE = 2'd2, HALTED = 2'd3.
- One combinational sub-module, pc_next_calc: inputs pc, instr, halt, jump, branch, alu_zero; output next pc. It keeps the priority logic and wrap rules unit-testable.

Test Plan:
- Reset and start: rst_n low, then high, then start pulse -> imem_req = 1 and imem_addr = 0 in the next cycle.
- Sequential fetch with 3-cycle ack latency, 4 instructions of opcode 0000 (no branch/jump/halt) with ex_done each:
  - imem_addr sequence 0, 1, 2, 3.
  - opcode = 0000 while instr_valid.
  - retire_cnt = 4.
- Jump: instr 16'h7_0A5 with jump = 1 at ex_done -> next imem_addr = 8'hA5.
- Branch at pc = 8'h10, offset instr[7:0] = 8'hFC:
  - branch = 1, alu_zero = 1 -> next pc = 8'h0D.
  - Same with alu_zero = 0 -> next pc = 8'h11.
- Wrap and halt:
  - pc = 8'hFF, no branch -> next pc = 8'h00.
  - Then halt = 1 at ex_done -> halted = 1, imem_req stays 0 for 20 cycles even with start and imem_ack pulsed.
- Reset mid-FETCH: assert rst_n low while imem_req = 1 -> imem_req = 0 immediately, pc = RESET_PC, then a late imem_ack is ignored (state stays IDLE).

Source files
------------

// File: rtl/mips_pkg.sv
// Shared field positions, widths and fetch-state encoding for the core front end.
// Imported by the fetch/issue controller and its next-PC calculator.
package mips_pkg;

    localparam int OPCODE_W = 4;
    localparam int INSTR_W  = 16;
    localparam int OPC_HI   = 15;
    localparam int OPC_LO   = 12;
    localparam int BR_OFF_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    // Sign-extends a branch offset to 32 bits; callers truncate to their PC width.
    function automatic logic [31:0] sext_off(input logic [BR_OFF_W-1:0] off);
        return {{(32-BR_OFF_W){off[BR_OFF_W-1]}}, off};
    endfunction

endpackage

// File: rtl/instr_fetch_issue_pc_next_calc.sv
// Next-PC selection: halt holds, jump loads instr low bits, taken branch adds
// the sign-extended offset to pc+1, otherwise pc+1. All arithmetic wraps at ADDR_W.
module pc_next_calc
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = mips_pkg::INSTR_W
) (
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic               halt,
    input  logic               jump,
    input  logic               branch,
    input  logic               alu_zero,
    output logic [ADDR_W-1:0]  pc_next
);

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] taken_pc;

    assign offset   = ADDR_W'(sext_off(instr[BR_OFF_W-1:0]));
    assign seq_pc   = pc + ADDR_W'(1);
    assign taken_pc = seq_pc + offset;

    // Upper instruction bits only feed the opcode path, not the PC.
    logic unused_instr;
    assign unused_instr = ^instr[INSTR_W-1:ADDR_W];

    always_comb begin
        pc_next = seq_pc;
        if (halt)
            pc_next = pc;
        else if (jump)
            pc_next = instr[ADDR_W-1:0];
        else if (branch && alu_zero)
            pc_next = taken_pc;
    end

endmodule

// File: rtl/instr_fetch_issue.sv
// Front end: fetches instructions over a req/ack handshake, presents them for
// decode/execute, and owns the PC, run/halt state and retired-instruction count.
//
// state  | meaning
// IDLE   | waiting for start after reset
// FETCH  | imem_req high at pc, waiting for imem_ack
// ISSUE  | instr valid, waiting for ex_done to pick next pc
// HALTED | stopped by a halt instruction until reset
module instr_fetch_issue
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = mips_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                imem_ack,
    output logic [INSTR_W-1:0]  instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic                instr_valid,
    input  logic                ex_done,
    input  logic                branch,
    input  logic                jump,
    input  logic                halt,
    input  logic                alu_zero,
    output logic [ADDR_W-1:0]   pc,
    output logic                halted,
    output logic [15:0]         retire_cnt
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc_next;

    pc_next_calc #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_pc_next (
        .pc       (pc),
        .instr    (instr),
        .halt     (halt),
        .jump     (jump),
        .branch   (branch),
        .alu_zero (alu_zero),
        .pc_next  (pc_next)
    );

    assign imem_addr = pc;
    assign opcode    = instr[OPC_HI:OPC_LO];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            retire_cnt  <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        state       <= ISSUE;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (ex_done) begin
                        instr_valid <= 1'b0;
                        if (retire_cnt != 16'hFFFF)
                            retire_cnt <= retire_cnt + 16'd1;
                        // Halt is retired like any other instruction but ends fetching.
                        if (halt) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            pc       <= pc_next;
                            state    <= FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
